// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline stages.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  // All-zero word decodes as sll $0,$0,0, so a cleared instruction register is a harmless bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Occupancy of a two-entry skid buffer: main only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage : mips_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating event counter shared by the pipeline stages for performance statistics.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  // Count one per cycle with inc high, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule : pipe_sat_counter

// File: rtl/if_id_stage_reg.sv
// IF->ID elastic pipeline register: two-entry skid buffer carrying instruction and PC+4,
// with a registered in_ready, flush-to-bubble and a decode back-pressure counter.
module if_id_stage_reg #(
  parameter int INSTR_W = mips_pkg::INSTR_W,
  parameter int PC_W    = mips_pkg::PC_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc_plus4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic [CNT_W-1:0]   stall_cnt
);

  import mips_pkg::*;

  localparam logic [INSTR_W-1:0] L_NOP = INSTR_W'(NOP_INSTR);

  skid_state_t        r_state;
  skid_state_t        w_state_nxt;
  logic               r_in_ready;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_stall;

  assign w_out_valid = (r_state != EMPTY);
  assign w_in_fire   = in_valid && r_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;
  assign w_stall     = w_out_valid && !out_ready;

  assign in_ready     = r_in_ready;
  assign out_valid    = w_out_valid;
  // A consumed beat may linger in the main register; mask it so decode only ever sees a bubble.
  assign out_instr    = w_out_valid ? r_main_instr : L_NOP;
  assign out_pc_plus4 = w_out_valid ? r_main_pc    : '0;

  // State register; in_ready is precomputed from the next state so it leaves a flop directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // Next-state and data-load decisions; flush wins over every handshake.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_load_skid = 1'b1;
            w_state_nxt = FULL;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so nothing new arrives; the skid beat moves up in order.
          if (w_out_fire) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Beat storage: loads only on accept, so a stalled beat never changes under decode.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these data registers are reset as well, so no stale beat survives a reset.
    if (!rst_n) begin
      r_main_instr <= L_NOP;
      r_main_pc    <= '0;
      r_skid_instr <= L_NOP;
      r_skid_pc    <= '0;
    end else if (flush_i) begin
      r_main_instr <= L_NOP;
      r_main_pc    <= '0;
      r_skid_instr <= L_NOP;
      r_skid_pc    <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_instr <= in_instr;
        r_main_pc    <= in_pc_plus4;
      end else if (w_load_main_skid) begin
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
      end
      if (w_load_skid) begin
        r_skid_instr <= in_instr;
        r_skid_pc    <= in_pc_plus4;
      end
    end
  end

  // Decode back-pressure statistic; survives flushes, cleared only by reset.
  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .cnt   (stall_cnt)
  );

endmodule : if_id_stage_reg

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed reset, streaming, back-pressure, flush and
// saturation cases, then a randomized run against a queue-based reference model.
module tb_if_id_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc_plus4;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_instr;
  logic [31:0] s_out_pc_plus4;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_id_stage_reg dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc_plus4  (in_pc_plus4),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc_plus4 (out_pc_plus4),
    .stall_cnt    (stall_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for the saturation case.
  if_id_stage_reg #(.CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid     (in_valid),
    .in_ready     (s_in_ready),
    .in_instr     (in_instr),
    .in_pc_plus4  (in_pc_plus4),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_instr    (s_out_instr),
    .out_pc_plus4 (s_out_pc_plus4),
    .stall_cnt    (s_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid    = v;
    in_instr    = ins;
    in_pc_plus4 = pc;
    out_ready   = rdy;
    flush_i     = fl;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic ir, input logic [15:0] st);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".out_instr"}, 64'(out_instr), 64'(ins));
    check({tag, ".out_pc"},    64'(out_pc_plus4), 64'(pc));
    check({tag, ".in_ready"},  64'(in_ready), 64'(ir));
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(st));
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] A = 32'h8C88_0004, B = 32'h0109_5020, C = 32'h1000_FFFF;
  localparam logic [31:0] D = 32'h2129_0001, E = 32'hAD2A_0008, F = 32'h0800_0010;

  logic [63:0] q[$];
  logic [15:0] exp_stall;
  logic        exp_ir;
  logic        exp_ov;
  logic [63:0] exp_head;

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    expect_out("post_reset", 1'b0, 32'h0, 32'h0, 1'b1, 16'd0);

    // Fill to FULL with one stall cycle, then pull reset mid-cycle.
    drive(1'b1, A, 32'h0040_0004, 1'b0, 1'b0);
    tick();
    drive(1'b1, B, 32'h0040_0008, 1'b0, 1'b0);
    tick();
    expect_out("pre_rst_full", 1'b1, A, 32'h0040_0004, 1'b0, 16'd1);
    #3 rst_n = 1'b0;
    #1 expect_out("async_rst", 1'b0, 32'h0, 32'h0, 1'b1, 16'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out("rst_release", 1'b0, 32'h0, 32'h0, 1'b1, 16'd0);

    // Streaming: one beat per cycle, visible one cycle later.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h2008_0001 + 32'(i), 32'h0040_0004 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, 32'h2008_0001 + 32'(i),
                 32'h0040_0004 + 32'(4 * i), 1'b1, 16'd0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    expect_out("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 16'd0);

    // Back-pressure: A on out, B into skid, C held at the source.
    drive(1'b1, A, 32'h100, 1'b0, 1'b0);
    tick();
    expect_out("bp_a", 1'b1, A, 32'h100, 1'b1, 16'd0);
    drive(1'b1, B, 32'h104, 1'b0, 1'b0);
    tick();
    expect_out("bp_b_skid", 1'b1, A, 32'h100, 1'b0, 16'd1);
    drive(1'b1, C, 32'h108, 1'b0, 1'b0);
    tick();
    expect_out("bp_c_held1", 1'b1, A, 32'h100, 1'b0, 16'd2);
    tick();
    expect_out("bp_c_held2", 1'b1, A, 32'h100, 1'b0, 16'd3);
    out_ready = 1'b1;
    tick();
    expect_out("bp_out_b", 1'b1, B, 32'h104, 1'b1, 16'd3);
    tick();
    expect_out("bp_out_c", 1'b1, C, 32'h108, 1'b1, 16'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    expect_out("bp_empty", 1'b0, 32'h0, 32'h0, 1'b1, 16'd3);

    // Flush while FULL with a new beat offered: everything dropped, counter kept.
    drive(1'b1, D, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, E, 32'h204, 1'b0, 1'b0);
    tick();
    expect_out("fl_full", 1'b1, D, 32'h200, 1'b0, 16'd4);
    drive(1'b1, F, 32'h208, 1'b1, 1'b1);
    tick();
    expect_out("fl_bubble", 1'b0, 32'h0, 32'h0, 1'b1, 16'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    expect_out("fl_dropped", 1'b0, 32'h0, 32'h0, 1'b1, 16'd4);

    // Saturation on the 4-bit copy: 20 stalled cycles.
    do_reset();
    drive(1'b1, A, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (20) tick();
    check("sat.cnt4", 64'(s_stall_cnt), 64'd15);
    check("sat.cnt16", 64'(stall_cnt), 64'd20);
    check("sat.valid", 64'(s_out_valid), 64'd1);
    repeat (3) tick();
    check("sat.hold", 64'(s_stall_cnt), 64'd15);
    check("sat.cnt16b", 64'(stall_cnt), 64'd23);

    // Randomized traffic against a FIFO reference of depth two.
    do_reset();
    q.delete();
    exp_stall = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, $urandom,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      exp_ir   = (q.size() < 2);
      exp_ov   = (q.size() > 0);
      exp_head = exp_ov ? q[0] : 64'h0;
      check("rnd.in_ready", 64'(in_ready), 64'(exp_ir));
      check("rnd.out_valid", 64'(out_valid), 64'(exp_ov));
      check("rnd.out_data", {out_instr, out_pc_plus4}, exp_head);
      check("rnd.stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      if (exp_ov && !out_ready && (exp_stall != 16'hFFFF)) exp_stall++;
      if (exp_ov && out_ready) void'(q.pop_front());
      if (flush_i) q.delete();
      else if (in_valid && exp_ir) q.push_back({in_instr, in_pc_plus4});
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_if_id_stage_reg
